// File: rtl/cell_processor_pipe.sv
// cell_processor_pipe: handshaked WIN x WIN window processor with point ops and sequenced reductions
// Ports: clk, rst (async, active-low); in_valid/in_ready + opcode, cell_a, cell_b, user_in on the input side;
//        out_valid/out_ready + out_pixel, out_ovf on the output side.
// Opcodes: 0 ADD, 1 ADDI, 2 SUB, 3 SUBI, 4 AVG, 5 MAX, 6 MIN, 7 PASS.
// Build option CELL_PROC_SAT_EN: point-op overflow saturates to all ones, underflow clamps to zero (wraps otherwise).
module cell_processor_pipe #(
    parameter int PIXEL_W = 8,
    parameter int WIN = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 opcode,
    input  logic [WIN*WIN*PIXEL_W-1:0] cell_a,
    input  logic [WIN*WIN*PIXEL_W-1:0] cell_b,
    input  logic [PIXEL_W-1:0]         user_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PIXEL_W-1:0]         out_pixel,
    output logic                       out_ovf
);
    localparam int N = WIN * WIN;
    localparam int SUM_W = PIXEL_W + $clog2(N);
    localparam int CI = (WIN / 2) * WIN + WIN / 2;
    localparam int CW = $clog2((WIN > SUM_W ? WIN : SUM_W) + 1);
    localparam logic [2:0] OP_ADD = 3'd0, OP_ADDI = 3'd1, OP_SUB = 3'd2, OP_SUBI = 3'd3;
    localparam logic [2:0] OP_AVG = 3'd4, OP_MAX = 3'd5, OP_MIN = 3'd6;

    if (WIN < 3 || WIN % 2 == 0) begin : g_bad_win
        $error("cell_processor_pipe: WIN must be odd and >= 3");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, DIV, OUT} state_t;

    state_t               state, state_next;
    logic [2:0]           op;
    logic [N*PIXEL_W-1:0] a;
    logic [PIXEL_W-1:0]   bc, u, ca, opnd, pt, res;
    logic [PIXEL_W:0]     wide;
    logic [SUM_W-1:0]     acc, acc_fold, px, rem;
    logic [SUM_W:0]       rem_sh, rem_nx;
    logic [CW-1:0]        cnt;
    logic                 accept, free, red_in, is_red, is_add, is_sub, ovf, ge, last_row, last_bit;
    logic                 unused_bits;

    // Only the centre of window B matters; the MSB of the trial remainder is always dropped.
    assign unused_bits = ^{cell_b, rem_nx[SUM_W]};

    assign free     = !out_valid || out_ready;
    assign in_ready = rst && state == IDLE && free;
    assign accept   = in_valid && in_ready;
    assign red_in   = opcode inside {OP_AVG, OP_MAX, OP_MIN};
    assign last_row = cnt == CW'(WIN - 1);
    assign last_bit = cnt == CW'(SUM_W - 1);

    always_comb begin
        px = '0;
        acc_fold = acc;
        // Fold row cnt of window A into the accumulator (sum, max or min)
        for (int c = 0; c < WIN; c++) begin
            px = SUM_W'(a[(int'(cnt) * WIN + c) * PIXEL_W +: PIXEL_W]);
            acc_fold = op == OP_AVG ? acc_fold + px :
                       (op == OP_MAX && px > acc_fold) || (op == OP_MIN && px < acc_fold) ? px : acc_fold;
        end
        // Restoring division step: shift in the next dividend bit, subtract N when it fits
        rem_sh = {rem, acc[SUM_W-1]};
        ge = rem_sh >= (SUM_W + 1)'(N);
        rem_nx = ge ? rem_sh - (SUM_W + 1)'(N) : rem_sh;
        ca = a[CI*PIXEL_W +: PIXEL_W];
        is_red = op inside {OP_AVG, OP_MAX, OP_MIN};
        is_add = op == OP_ADD || op == OP_ADDI;
        is_sub = op == OP_SUB || op == OP_SUBI;
        opnd = (op == OP_ADD || op == OP_SUB) ? bc : u;
        wide = is_sub ? {1'b0, ca} - {1'b0, opnd} : {1'b0, ca} + {1'b0, opnd};
        // Carry out on add and borrow out on subtract both land in the extra bit
        ovf = (is_add || is_sub) && wide[PIXEL_W];
`ifdef CELL_PROC_SAT_EN
        pt = ovf ? (is_sub ? '0 : '1) : wide[PIXEL_W-1:0];
`else
        pt = wide[PIXEL_W-1:0];
`endif
        res = is_red ? acc[PIXEL_W-1:0] : (is_add || is_sub) ? pt : ca;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? (red_in ? ACCUM : OUT) : IDLE;
            ACCUM:   state_next = last_row ? (op == OP_AVG ? DIV : OUT) : ACCUM;
            DIV:     state_next = last_bit ? OUT : DIV;
            OUT:     state_next = free ? IDLE : OUT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op <= '0;
            a <= '0;
            bc <= '0;
            u <= '0;
            acc <= '0;
            rem <= '0;
            cnt <= '0;
            out_valid <= 1'b0;
            out_pixel <= '1;
            out_ovf <= 1'b0;
        end else begin
            if (accept) begin
                op <= opcode;
                a <= cell_a;
                bc <= cell_b[CI*PIXEL_W +: PIXEL_W];
                u <= user_in;
                acc <= opcode == OP_MIN ? '1 : '0;
                rem <= '0;
                cnt <= '0;
            end
            if (state == ACCUM) begin
                acc <= acc_fold;
                cnt <= last_row ? '0 : cnt + 1'b1;
            end
            if (state == DIV) begin
                acc <= {acc[SUM_W-2:0], ge};
                rem <= rem_nx[SUM_W-1:0];
                cnt <= cnt + 1'b1;
            end
            if (state == OUT && free) begin
                out_valid <= 1'b1;
                out_pixel <= res;
                out_ovf <= ovf;
            end else if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cell_processor_pipe.sv
// tb_cell_processor_pipe: directed and randomized checks of cell_processor_pipe against a behavioural model
module tb_cell_processor_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [2:0]  opcode;
    logic [71:0] cell_a, cell_b;
    logic [7:0]  user_in, out_pixel;

    int          n_cmp = 0, n_bad = 0, pend;
    logic [8:0]  q[$];
    logic [8:0]  e;
    logic        hold = 1'b0, h_ovf = 1'b0;
    logic [7:0]  h_pix = '0;

    cell_processor_pipe #(.PIXEL_W(8), .WIN(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .cell_a(cell_a), .cell_b(cell_b), .user_in(user_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_pixel(out_pixel), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Result {ovf, pixel} from the operation rules; centre pixel is pixel[1][1] = bits [39:32]
    function automatic logic [8:0] model(input logic [2:0] op, input logic [71:0] a, input logic [71:0] b,
                                         input logic [7:0] u);
        int ca, cb, t, sum, mx, mn, p;
        ca = int'(a[39:32]);
        cb = int'(b[39:32]);
        sum = 0;
        mx = 0;
        mn = 255;
        t = 0;
        for (int i = 0; i < 9; i++) begin
            p = int'(a[i*8 +: 8]);
            sum += p;
            if (p > mx) mx = p;
            if (p < mn) mn = p;
        end
        case (op)
            3'd0: t = ca + cb;
            3'd1: t = ca + int'(u);
            3'd2: t = ca - cb;
            3'd3: t = ca - int'(u);
            3'd4: return {1'b0, 8'(sum / 9)};
            3'd5: return {1'b0, 8'(mx)};
            3'd6: return {1'b0, 8'(mn)};
            default: return {1'b0, 8'(ca)};
        endcase
        if (t > 255 || t < 0)
`ifdef CELL_PROC_SAT_EN
            return {1'b1, t < 0 ? 8'd0 : 8'd255};
`else
            return {1'b1, 8'(t)};
`endif
        return {1'b0, 8'(t)};
    endfunction

    function automatic logic [71:0] rnd_cell();
        logic [71:0] c;
        for (int i = 0; i < 9; i++)
            c[i*8 +: 8] = ($urandom % 4 == 0) ? (($urandom % 2 == 0) ? 8'hFF : 8'h00) : 8'($urandom);
        return c;
    endfunction

    function automatic logic [71:0] with_centre(input logic [7:0] v);
        logic [71:0] c;
        c = rnd_cell();
        c[39:32] = v;
        return c;
    endfunction

    function automatic logic [71:0] pk(input int p[9]);
        logic [71:0] c;
        for (int i = 0; i < 9; i++) c[i*8 +: 8] = 8'(p[i]);
        return c;
    endfunction

    // Scoreboard: every accepted transaction must come out once, in order, with the model's value
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            hold = 1'b0;
        end else begin
            pend = q.size() - (out_valid ? 1 : 0);
            chk("in_ready", int'(in_ready), int'(pend == 0 && (!out_valid || out_ready)));
            if (out_valid) chk("valid_has_txn", int'(q.size() > 0), 1);
            if (hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_pixel", int'(out_pixel), int'(h_pix));
                chk("hold_ovf", int'(out_ovf), int'(h_ovf));
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("pixel", int'(out_pixel), int'(e[7:0]));
                chk("ovf", int'(out_ovf), int'(e[8]));
            end
            hold = out_valid && !out_ready;
            h_pix = out_pixel;
            h_ovf = out_ovf;
            if (in_valid && in_ready) q.push_back(model(opcode, cell_a, cell_b, user_in));
        end
    end

    // Offer one transaction, then count clock edges from acceptance until out_valid rises
    task automatic send(input logic [2:0] op, input logic [71:0] a, input logic [71:0] b, input logic [7:0] u,
                        output int lat, output logic [7:0] px, output logic ov);
        int k;
        lat = -1;
        px = '0;
        ov = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        opcode = op;
        cell_a = a;
        cell_b = b;
        user_in = u;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 50);
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode = 3'($urandom);
        cell_a = rnd_cell();
        cell_b = rnd_cell();
        user_in = 8'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 60);
        px = out_pixel;
        ov = out_ovf;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ok;
        logic [7:0] px;
        logic ov;
        int win[9];
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        opcode = '0;
        cell_a = '0;
        cell_b = '0;
        user_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pixel", int'(out_pixel), 255);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);

        send(3'd0, with_centre(8'd200), with_centre(8'd100), 8'($urandom), lat, px, ov);
        chk("add_lat", lat, 1);
`ifdef CELL_PROC_SAT_EN
        chk("add_pixel", int'(px), 255);
`else
        chk("add_pixel", int'(px), 44);
`endif
        chk("add_ovf", int'(ov), 1);

        send(3'd3, with_centre(8'd10), rnd_cell(), 8'd20, lat, px, ov);
        chk("subi_lat", lat, 1);
`ifdef CELL_PROC_SAT_EN
        chk("subi_pixel", int'(px), 0);
`else
        chk("subi_pixel", int'(px), 246);
`endif
        chk("subi_ovf", int'(ov), 1);

        send(3'd7, with_centre(8'd77), rnd_cell(), 8'd200, lat, px, ov);
        chk("pass_pixel", int'(px), 77);
        chk("pass_ovf", int'(ov), 0);

        win = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        send(3'd4, pk(win), rnd_cell(), 8'd0, lat, px, ov);
        chk("avg_lat", lat, 16);
        chk("avg_pixel", int'(px), 5);
        win = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        send(3'd4, pk(win), rnd_cell(), 8'd0, lat, px, ov);
        chk("avg255_lat", lat, 16);
        chk("avg255_pixel", int'(px), 255);
        chk("avg255_ovf", int'(ov), 0);

        win = '{9, 3, 7, 1, 5, 8, 2, 6, 4};
        send(3'd5, pk(win), rnd_cell(), 8'd0, lat, px, ov);
        chk("max_lat", lat, 4);
        chk("max_pixel", int'(px), 9);
        send(3'd6, pk(win), rnd_cell(), 8'd0, lat, px, ov);
        chk("min_lat", lat, 4);
        chk("min_pixel", int'(px), 1);

        // Backpressure, then accept a new transaction in the draining cycle
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(3'd0, with_centre(8'd5), with_centre(8'd6), 8'd0, lat, px, ov);
        chk("bp_lat", lat, 1);
        in_valid = 1'b1;
        opcode = 3'd7;
        cell_a = with_centre(8'd33);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_pixel", int'(out_pixel), 11);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("drain_cleared", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("b2b_valid", int'(out_valid), 1);
        chk("b2b_pixel", int'(out_pixel), 33);

        // Reset in the middle of an AVG
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        opcode = 3'd4;
        cell_a = rnd_cell();
        do @(negedge clk); while (!in_ready);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_pixel", int'(out_pixel), 255);
        chk("mid_rst_ovf", int'(out_ovf), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", int'(in_ready), 1);
        ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) ok = 0;
        end
        chk("no_stray_valid", ok, 1);
        send(3'd0, with_centre(8'd1), with_centre(8'd2), 8'd0, lat, px, ov);
        chk("after_rst_add", int'(px), 3);
        chk("after_rst_ovf", int'(ov), 0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            in_valid = $urandom % 3 != 0;
            opcode = 3'($urandom);
            cell_a = rnd_cell();
            cell_b = rnd_cell();
            user_in = ($urandom % 4 == 0) ? 8'hFF : 8'($urandom);
            out_ready = $urandom % 4 != 0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", q.size(), 0);
        chk("drain_valid", int'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cell_processor_pipe.md
Name: cell_processor_pipe

Overview:
- Parametrised, handshaked successor to the combinational cell processor.
- Accepts one WIN x WIN pixel window pair plus opcode and user operand per transaction.
- Point ops on the centre pixel complete in one cycle. Window reductions (AVG/MAX/MIN) run as a multi-cycle sequenced datapath.
- Sits between the window-buffer stage and the output pixel writer.

Parameters:
PIXEL_W, 8, bits per pixel
WIN, 3, window edge length; odd, >=3 (elaboration error otherwise)
SUM_W, PIXEL_W+$clog2(WIN*WIN), accumulator/divider width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  transaction offered
in_ready  out  1  block can accept
opcode  in  3  0 ADD, 1 ADDI, 2 SUB, 3 SUBI, 4 AVG, 5 MAX, 6 MIN, 7 PASS
cell_a  in  WIN*WIN*PIXEL_W  window A, row-major; pixel[r][c] at bit offset (r*WIN+c)*PIXEL_W
cell_b  in  WIN*WIN*PIXEL_W  window B, same layout
user_in  in  PIXEL_W  immediate operand
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_pixel  out  PIXEL_W  result
out_ovf  out  1  result overflowed/underflowed (ADD/ADDI/SUB/SUBI only, else 0)

Behaviour:
- Reset values: out_valid=0, out_pixel=all ones, out_ovf=0, state=IDLE; in_ready=0 while rst low.
- Reset mid-operation aborts the operation with no output.
- Accept: in_valid & in_ready. On accept, opcode, cell_a, cell_b and user_in are registered; later input changes are ignored.
- in_ready = (state==IDLE) & (!out_valid | out_ready). This allows back-to-back acceptance in the same cycle the prior result drains.
- Output hold: out_valid, out_pixel and out_ovf stay stable until out_valid & out_ready. out_valid clears the cycle after the handshake unless a new result lands.
- Centre pixel: C = pixel[WIN/2][WIN/2].
- Point ops (ADD A.C+B.C, ADDI A.C+user_in, SUB A.C-B.C, SUBI A.C-user_in, PASS A.C): accept at T gives out_valid at T+1.
- FSM states: IDLE, ACCUM, DIV, OUT.
- MAX/MIN: IDLE -> ACCUM for WIN cycles, folding one row of cell_a per cycle (row 0 first) -> OUT. out_valid at T+WIN+1.
- AVG: ACCUM sums one row per cycle into SUM_W accumulator (WIN cycles) -> DIV runs a restoring division by WIN*WIN, one quotient bit per cycle (SUM_W cycles) -> OUT. Result is floor(sum/(WIN*WIN)); out_valid at T+WIN+SUM_W+1.
- OUT waits for a free output register (out_valid=0 or draining), then loads the result and returns to IDLE.
- Arithmetic:
  - ADD/SUB computed in PIXEL_W+1 bits.
  - out_ovf=1 when the true result is >2^PIXEL_W-1 or <0.
  - AVG/MAX/MIN never overflow.

Optional Feature:
- Macro: CELL_PROC_SAT_EN.
- Defined: overflow saturates to 2^PIXEL_W-1; underflow clamps to 0.
- Undefined: results wrap modulo 2^PIXEL_W.
- out_ovf behaves identically in both builds.

Test Plan:
- PIXEL_W=8, WIN=3, ADD A.C=200, B.C=100 -> out_pixel 255 (SAT_EN) / 44 (no SAT_EN), out_ovf=1, out_valid at T+1.
- SUBI A.C=10, user_in=20 -> 0 (SAT_EN) / 246 (no SAT_EN), out_ovf=1. Also PASS A.C=77 -> 77, out_ovf=0.
- AVG, cell_a = 1..9 row-major -> 5 at T+16; in_ready=0 for T+1..T+16. Repeat with all-255 window -> 255.
- MAX/MIN, cell_a = {9,3,7,1,5,8,2,6,4} -> 9 and 1 respectively, each at T+4.
- Backpressure: out_ready=0 for 3 cycles after a result -> out_pixel/out_valid held, in_ready=0. Raise out_ready with in_valid=1 -> new transaction accepted in the draining cycle, no result lost or duplicated.
- Assert rst at cycle 5 of an AVG -> outputs return to reset values immediately. After release: in_ready=1, no stray out_valid, next ADD 1+2 -> 3.
